// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, opcode field position, widths.
// Pure declarations, no logic.
package instr_fetch_unit_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 26;
  localparam int OPC_W      = OPC_MSB - OPC_LSB + 1;
  localparam int PC_INC     = 4;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC adder: pc+4, plus sign-extended word offset when the branch is taken.
// Purely combinational (0 cycles), no flow control.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              taken,
  input  logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] offset;

  always_comb begin
    pc_plus4 = pc + ADDR_W'(PC_INC);
    offset   = {{(ADDR_W-16){imm[15]}}, imm} << 2;
    next_pc  = pc_plus4 + (taken ? offset : '0);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC + fetch FSM issuing one instruction per FETCH/WAIT/ISSUE round; optional perf counters under IFU_PERF_EN.
// Latency >= 3 cycles per instruction; stalls in ISSUE while instr_ready is low, retries fetch on memory timeout.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_rvalid,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPC_W-1:0]    opcode,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [ADDR_W-1:0]   pc_plus4,
  input  logic                branch,
  input  logic                zero,
  input  logic [15:0]         branch_imm,
  output logic                fetch_err,
  output logic [31:0]         perf_retired,
  output logic [31:0]         perf_taken
);

  localparam logic [ADDR_W-1:0]     PC_RST   = RESET_PC & ~ADDR_W'(3);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MAX_WAIT);

  fetch_state_t           state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic                   imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]      imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   fetch_err_q, fetch_err_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_inc;
  logic                   xfer, taken;
  logic [ADDR_W-1:0]      next_pc;

  assign xfer  = instr_valid_q & instr_ready;
  assign taken = branch & zero;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc       (pc_q),
    .taken    (taken),
    .imm      (branch_imm),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    wait_inc      = wait_cnt_q + 1'b1;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
        wait_cnt_d  = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A response on the timeout cycle still counts; the timeout only fires without one.
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == WAIT_MAX) begin
            fetch_err_d = 1'b1;
            imem_req_d  = 1'b0;
            state_d     = S_FETCH;
          end
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      pc_q          <= PC_RST;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_taken_q, perf_taken_d;

  always_comb begin
    perf_retired_d = perf_retired_q + {31'd0, xfer};
    perf_taken_d   = perf_taken_q + {31'd0, xfer & taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_taken_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_taken_q   <= perf_taken_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_taken   = perf_taken_q;
`else
  assign perf_retired = '0;
  assign perf_taken   = '0;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: RESET_PC=0x40, MAX_WAIT=3, memory responses driven by the stimulus.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        zero;
  logic [15:0] branch_imm;
  logic        fetch_err;
  logic [31:0] perf_retired;
  logic [31:0] perf_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0040),
    .MAX_WAIT (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .branch       (branch),
    .zero         (zero),
    .branch_imm   (branch_imm),
    .fetch_err    (fetch_err),
    .perf_retired (perf_retired),
    .perf_taken   (perf_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until imem_req is seen high (bounded).
  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (imem_req !== 1'b1 && n < 20);
    if (imem_req !== 1'b1) chk("req_never_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Called with imem_req visible; answers after lat cycles, then holds ready low for stall cycles.
  task automatic respond_issue(input logic [31:0] addr, input logic [31:0] data, input int lat,
                               input int stall, input logic br, input logic zr, input logic [15:0] imm);
    logic [5:0] exp_opc;
    exp_opc = data[31:26];
    chk("imem_addr", imem_addr, addr);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, addr);
    end
    imem_rdata  = data;
    imem_rvalid = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("valid_on_issue", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, data);
    chk("opcode", {26'd0, opcode}, {26'd0, exp_opc});
    chk("pc_out", pc_out, addr);
    chk("pc_plus4", pc_plus4, addr + 32'd4);
    chk("req_dropped", {31'd0, imem_req}, 32'd0);
    chk("no_fetch_err", {31'd0, fetch_err}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, data);
      chk("stall_pc", pc_out, addr);
      chk("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    branch      = br;
    zero        = zr;
    branch_imm  = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    branch      = 1'b1;
    zero        = 1'b1;
    branch_imm  = 16'h5A5A;
    chk("valid_dropped", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic fetch_one(input logic [31:0] addr, input int gap, input logic [31:0] data,
                           input int lat, input int stall, input logic br, input logic zr,
                           input logic [15:0] imm);
    int n;
    wait_req(n);
    chk("req_gap", n, gap);
    respond_issue(addr, data, lat, stall, br, zr, imm);
  endtask

  initial begin
    int          n;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_tkn;

    rst_n       = 1'b0;
    imem_rdata  = 32'h0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    branch_imm  = 16'h0;
    repeat (3) @(negedge clk);

    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_pc", pc_out, 32'h40);
    chk("rst_pc_plus4", pc_plus4, 32'h44);
    chk("rst_perf_ret", perf_retired, 32'd0);
    chk("rst_perf_tkn", perf_taken, 32'd0);
    rst_n = 1'b1;

    // Sequential stream, one instruction per three cycles.
    fetch_one(32'h40, 2, 32'h8C01_0004, 1, 0, 1'b0, 1'b0, 16'h0000);
    fetch_one(32'h44, 1, 32'h2002_0005, 1, 0, 1'b0, 1'b1, 16'h0010);
    // 0x48 + 4 + 0x2D*4 = 0x100
    fetch_one(32'h48, 1, 32'h1000_002D, 1, 0, 1'b1, 1'b1, 16'h002D);
    // 0x100 + 4 - 8 = 0xFC
    fetch_one(32'h100, 1, 32'h1000_FFFE, 1, 0, 1'b1, 1'b1, 16'hFFFE);
    // branch low: not taken despite zero -> 0x100
    fetch_one(32'hFC, 1, 32'h1000_0001, 1, 0, 1'b0, 1'b1, 16'h0001);
    // zero low: not taken -> 0x104
    fetch_one(32'h100, 1, 32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 16'hFFFE);
    // five-cycle stall, accept on the sixth
    fetch_one(32'h104, 1, 32'hAC03_0008, 2, 5, 1'b0, 1'b0, 16'h0000);

    // Timeout at 0x108: three silent WAIT cycles, then a one-cycle error pulse and a retry.
    wait_req(n);
    chk("req_gap_to", n, 1);
    chk("to_addr", imem_addr, 32'h108);
    repeat (2) @(negedge clk);
    chk("to_pending_no_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    chk("to_err_pulse", {31'd0, fetch_err}, 32'd1);
    chk("to_req_dropped", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("to_err_one_cycle", {31'd0, fetch_err}, 32'd0);
    chk("to_retry_req", {31'd0, imem_req}, 32'd1);
    // Response lands on the timeout cycle: accepted, no error. 0x10C - 0x110 = 0xFFFFFFFC
    respond_issue(32'h108, 32'h1000_FFBC, 3, 0, 1'b1, 1'b1, 16'hFFBC);

    // Wrap: 0xFFFFFFFC + 4 = 0
    fetch_one(32'hFFFF_FFFC, 1, 32'h0000_0020, 1, 0, 1'b0, 1'b0, 16'h0000);

    // Reset while waiting on memory at address 0.
    wait_req(n);
    chk("pre_rst_addr", imem_addr, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, imem_req}, 32'd0);
    chk("rst_async_pc", pc_out, 32'h40);
    chk("rst_async_perf", perf_retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ten instructions after reset, taken branches at i = 2, 5, 8 (skip one word each).
    exp_pc = 32'h40;
    for (int i = 0; i < 10; i++) begin
      logic tk;
      tk = (i == 2) || (i == 5) || (i == 8);
      if (i == 3)
        fetch_one(exp_pc, (i == 0) ? 2 : 1, 32'h0000_0000 | i, 1, 0, 1'b0, 1'b1, 16'h0001);
      else if (i == 4)
        fetch_one(exp_pc, (i == 0) ? 2 : 1, 32'h1000_0001, 1, 0, 1'b1, 1'b0, 16'h0001);
      else
        fetch_one(exp_pc, (i == 0) ? 2 : 1, 32'h1000_0001, 1, 0, tk, tk, 16'h0001);
      exp_pc = exp_pc + (tk ? 32'd8 : 32'd4);
    end
    chk("final_pc", pc_out, 32'h74);

`ifdef IFU_PERF_EN
    exp_ret = 32'd10;
    exp_tkn = 32'd3;
`else
    exp_ret = 32'd0;
    exp_tkn = 32'd0;
`endif
    chk("perf_retired", perf_retired, exp_ret);
    chk("perf_taken", perf_taken, exp_tkn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
